// File: rtl/tinyvga_dither_out.sv
// tinyvga_dither_out
//   Output stage for the TinyVGA PMOD. Quantises 8-bit RGB to 2 bits per
//   channel with a 4x4 ordered (Bayer) dither. The pattern can rotate from
//   frame to frame. The block delay-aligns hsync/vsync/display_on with the
//   pixel path, applies blanking, and owns the frame counter.
// Ports
//   clk, reset          pixel clock; asynchronous active-high reset
//   hsync_in, vsync_in  active-high raw syncs
//   display_on          visible-area flag
//   hpos_lsb, vpos_lsb  low position bits aligned with r/g/b_in
//   r_in, g_in, b_in    8-bit colour
//   dither_en           0 = plain truncation to c[7:6]
//   uo_out              {hs,B[0],G[0],R[0],vs,B[1],G[1],R[1]}
//   frame_count         frames elapsed since reset (wraps)
//   frame_tick          one-clk pulse when frame_count advances
module tinyvga_dither_out #(
   parameter int unsigned SYNC_DELAY = 0,
   parameter int unsigned FRAME_W    = 12,
   parameter bit          TEMPORAL   = 1'b1,
   parameter bit          HSYNC_INV  = 1'b1,
   parameter bit          VSYNC_INV  = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               hsync_in,
   input  logic               vsync_in,
   input  logic               display_on,
   input  logic [1:0]         hpos_lsb,
   input  logic [1:0]         vpos_lsb,
   input  logic [7:0]         r_in,
   input  logic [7:0]         g_in,
   input  logic [7:0]         b_in,
   input  logic               dither_en,
   output logic [7:0]         uo_out,
   output logic [FRAME_W-1:0] frame_count,
   output logic               frame_tick
);

   // uo_out_q is the final sync stage, so only 1+SYNC_DELAY stages live here.
   localparam int unsigned SD = 1 + SYNC_DELAY;

   logic [SD-1:0]      hs_pipe_q, hs_pipe_d;
   logic [SD-1:0]      vs_pipe_q, vs_pipe_d;
   logic [SD-1:0]      de_pipe_q, de_pipe_d;

   logic [7:0]         r_q, g_q, b_q;
   logic [1:0]         hpos_q, vpos_q;
   logic               den_q;

   logic [7:0]         uo_out_q, uo_out_d;
   logic               vs_q;
   logic [FRAME_W-1:0] frame_count_q, frame_count_d;
   logic               frame_tick_q, frame_tick_d;

   function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] t;
      case ({row, col})
         4'h0: t = 4'd0;   4'h1: t = 4'd8;   4'h2: t = 4'd2;   4'h3: t = 4'd10;
         4'h4: t = 4'd12;  4'h5: t = 4'd4;   4'h6: t = 4'd14;  4'h7: t = 4'd6;
         4'h8: t = 4'd3;   4'h9: t = 4'd11;  4'hA: t = 4'd1;   4'hB: t = 4'd9;
         4'hC: t = 4'd15;  4'hD: t = 4'd7;   4'hE: t = 4'd13;  default: t = 4'd5;
      endcase
      return t;
   endfunction

   // Round up by one level when the dropped fraction beats the threshold.
   // Level 3 saturates; c[1:0] never matters.
   function automatic logic [1:0] quant(input logic [7:0] c, input logic [3:0] t,
                                        input logic en);
      logic [1:0] q;
      q = c[7:6];
      if (en && (c[5:2] > t) && (q != 2'd3)) q = q + 2'd1;
      return q;
   endfunction

   logic [1:0] off, col;
   logic [3:0] thr;
   logic [1:0] rq, gq, bq;
   logic       hs_o, vs_o, de_o;
   logic       vs_rise;

   always_comb begin
      hs_pipe_d    = hs_pipe_q;
      vs_pipe_d    = vs_pipe_q;
      de_pipe_d    = de_pipe_q;
      hs_pipe_d[0] = hsync_in;
      vs_pipe_d[0] = vsync_in;
      de_pipe_d[0] = display_on;
      for (int i = 1; i < int'(SD); i++) begin
         hs_pipe_d[i] = hs_pipe_q[i-1];
         vs_pipe_d[i] = vs_pipe_q[i-1];
         de_pipe_d[i] = de_pipe_q[i-1];
      end
   end

   always_comb begin
      off  = TEMPORAL ? frame_count_q[1:0] : 2'd0;
      col  = hpos_q + off;
      thr  = bayer(vpos_q, col);
      rq   = quant(r_q, thr, den_q);
      gq   = quant(g_q, thr, den_q);
      bq   = quant(b_q, thr, den_q);
      hs_o = hs_pipe_q[SD-1] ^ HSYNC_INV;
      vs_o = vs_pipe_q[SD-1] ^ VSYNC_INV;
      de_o = de_pipe_q[SD-1];
      if (!de_o) begin
         rq = 2'd0;
         gq = 2'd0;
         bq = 2'd0;
      end
      uo_out_d = {hs_o, bq[0], gq[0], rq[0], vs_o, bq[1], gq[1], rq[1]};
   end

   // The frame counter watches the undelayed vsync, so upstream animation
   // sees the new count early in vertical blank.
   always_comb begin
      vs_rise       = vsync_in & ~vs_q;
      frame_count_d = frame_count_q + (vs_rise ? FRAME_W'(1) : FRAME_W'(0));
      frame_tick_d  = vs_rise;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hs_pipe_q     <= '0;
         vs_pipe_q     <= '0;
         de_pipe_q     <= '0;
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
         hpos_q        <= '0;
         vpos_q        <= '0;
         den_q         <= 1'b0;
         uo_out_q      <= {HSYNC_INV, 3'b000, VSYNC_INV, 3'b000};
         vs_q          <= 1'b0;
         frame_count_q <= '0;
         frame_tick_q  <= 1'b0;
      end else begin
         hs_pipe_q     <= hs_pipe_d;
         vs_pipe_q     <= vs_pipe_d;
         de_pipe_q     <= de_pipe_d;
         r_q           <= r_in;
         g_q           <= g_in;
         b_q           <= b_in;
         hpos_q        <= hpos_lsb;
         vpos_q        <= vpos_lsb;
         den_q         <= dither_en;
         uo_out_q      <= uo_out_d;
         vs_q          <= vsync_in;
         frame_count_q <= frame_count_d;
         frame_tick_q  <= frame_tick_d;
      end
   end

   assign uo_out      = uo_out_q;
   assign frame_count = frame_count_q;
   assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_tinyvga_dither_out.sv
module tb_tinyvga_dither_out;

   logic       clk = 1'b0;
   logic       reset;
   logic       hsync_in, vsync_in, display_on, dither_en;
   logic [1:0] hpos_lsb, vpos_lsb;
   logic [7:0] r_in, g_in, b_in;

   logic [7:0]  uo0, uo1;
   logic [2:0]  fc0;
   logic [11:0] fc1;
   logic        tk0, tk1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // dut0: static pattern, no extra sync delay, 3-bit frame counter
   tinyvga_dither_out #(.SYNC_DELAY(0), .FRAME_W(3), .TEMPORAL(1'b0),
                        .HSYNC_INV(1'b1), .VSYNC_INV(1'b1)) dut0 (
      .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .display_on(display_on), .hpos_lsb(hpos_lsb), .vpos_lsb(vpos_lsb),
      .r_in(r_in), .g_in(g_in), .b_in(b_in), .dither_en(dither_en),
      .uo_out(uo0), .frame_count(fc0), .frame_tick(tk0));

   // dut1: rotating pattern, 3 extra sync clks, 12-bit frame counter
   tinyvga_dither_out #(.SYNC_DELAY(3), .FRAME_W(12), .TEMPORAL(1'b1),
                        .HSYNC_INV(1'b1), .VSYNC_INV(1'b1)) dut1 (
      .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .display_on(display_on), .hpos_lsb(hpos_lsb), .vpos_lsb(vpos_lsb),
      .r_in(r_in), .g_in(g_in), .b_in(b_in), .dither_en(dither_en),
      .uo_out(uo1), .frame_count(fc1), .frame_tick(tk1));

   typedef struct {
      logic [1:0] hp, vp;
      logic [7:0] r, g, b;
      logic       den, disp;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[24];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Raise vsync for hi clks, then drop it for lo clks; count ticks seen on each DUT.
   task automatic vs_pulse(input int hi, input int lo, output int t0, output int t1);
      t0 = 0; t1 = 0;
      vsync_in = 1'b1;
      for (int i = 0; i < hi; i++) begin
         @(negedge clk);
         t0 += int'(tk0); t1 += int'(tk1);
      end
      vsync_in = 1'b0;
      for (int i = 0; i < lo; i++) begin
         @(negedge clk);
         t0 += int'(tk0); t1 += int'(tk1);
      end
   endtask

   initial begin
      int t0, t1;
      logic [7:0] e;

      // r=0x20 sweep, TEMPORAL=0: R=1 (0x98) where T<8, else R=0 (0x88)
      tbl[0]  = '{2'd0, 2'd0, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h98};
      tbl[1]  = '{2'd1, 2'd0, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h88};
      tbl[2]  = '{2'd2, 2'd0, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h98};
      tbl[3]  = '{2'd3, 2'd0, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h88};
      tbl[4]  = '{2'd0, 2'd1, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h88};
      tbl[5]  = '{2'd1, 2'd1, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h98};
      tbl[6]  = '{2'd2, 2'd1, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h88};
      tbl[7]  = '{2'd3, 2'd1, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h98};
      tbl[8]  = '{2'd0, 2'd2, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h98};
      tbl[9]  = '{2'd1, 2'd2, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h88};
      tbl[10] = '{2'd2, 2'd2, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h98};
      tbl[11] = '{2'd3, 2'd2, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h88};
      tbl[12] = '{2'd0, 2'd3, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h88};
      tbl[13] = '{2'd1, 2'd3, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h98};
      tbl[14] = '{2'd2, 2'd3, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h88};
      tbl[15] = '{2'd3, 2'd3, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 8'h98};
      // truncation: R=2 G=1 B=3
      tbl[16] = '{2'd0, 2'd0, 8'h80, 8'h40, 8'hC0, 1'b0, 1'b1, 8'hED};
      // blanking wins over full-scale colour
      tbl[17] = '{2'd0, 2'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h88};
      // G=2 frac 15: bumps to 3 at T=0, stays 2 at T=15
      tbl[18] = '{2'd0, 2'd0, 8'h00, 8'hBC, 8'h00, 1'b1, 1'b1, 8'hAA};
      tbl[19] = '{2'd0, 2'd3, 8'h00, 8'hBC, 8'h00, 1'b1, 1'b1, 8'h8A};
      // B=1 frac 15: dithered to 2, truncated stays 1
      tbl[20] = '{2'd0, 2'd0, 8'h00, 8'h00, 8'h7C, 1'b1, 1'b1, 8'h8C};
      tbl[21] = '{2'd0, 2'd0, 8'h00, 8'h00, 8'h7C, 1'b0, 1'b1, 8'hC8};
      // c[1:0] ignored: frac 8 vs T=8 no bump, frac 9 bumps
      tbl[22] = '{2'd1, 2'd0, 8'h23, 8'h00, 8'h00, 1'b1, 1'b1, 8'h88};
      tbl[23] = '{2'd1, 2'd0, 8'h24, 8'h00, 8'h00, 1'b1, 1'b1, 8'h98};

      reset = 1'b1;
      hsync_in = 1'b0; vsync_in = 1'b0; display_on = 1'b1; dither_en = 1'b0;
      hpos_lsb = 2'd0; vpos_lsb = 2'd0;
      r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
      #1;
      chk("reset_uo0", uo0, 8'h88);
      chk("reset_uo1", uo1, 8'h88);
      chk("reset_fc0", fc0, 0);
      chk("reset_fc1", fc1, 0);
      chk("reset_tick", {tk1, tk0}, 0);
      repeat (2) @(negedge clk);
      chk("reset_hold_uo0", uo0, 8'h88);
      reset = 1'b0;

      // first two clks after release are blank, then full white
      @(negedge clk); chk("post_rst_k1_uo0", uo0, 8'h88);
      @(negedge clk); chk("post_rst_k2_uo0", uo0, 8'hFF);
      chk("post_rst_k2_uo1", uo1, 8'h88);
      repeat (3) @(negedge clk); chk("post_rst_k5_uo1", uo1, 8'hFF);

      for (int i = 0; i < 24; i++) begin
         hpos_lsb = tbl[i].hp; vpos_lsb = tbl[i].vp;
         r_in = tbl[i].r; g_in = tbl[i].g; b_in = tbl[i].b;
         dither_en = tbl[i].den; display_on = tbl[i].disp;
         repeat (2) @(negedge clk);
         chk($sformatf("vec%0d", i), uo0, tbl[i].exp);
      end

      // r=0xFF saturates at 3 everywhere
      r_in = 8'hFF; g_in = 8'h00; b_in = 8'h00; dither_en = 1'b1; display_on = 1'b1;
      for (int p = 0; p < 16; p++) begin
         hpos_lsb = 2'(p); vpos_lsb = 2'(p >> 2);
         repeat (2) @(negedge clk);
         chk($sformatf("sat_pos%0d", p), uo0, 8'h99);
      end

      // mid-frame reset discards pipeline immediately
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_uo0", uo0, 8'h88);
      chk("midrst_uo1", uo1, 8'h88);
      @(negedge clk);
      reset = 1'b0;

      // sync delay: blank display, one-clk hsync pulse
      r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF; display_on = 1'b0;
      repeat (6) @(negedge clk);
      hsync_in = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         hsync_in = 1'b0;
         e = (k == 2) ? 8'h08 : 8'h88;
         chk($sformatf("hs_d0_k%0d", k), uo0, e);
         e = (k == 5) ? 8'h08 : 8'h88;
         chk($sformatf("hs_d3_k%0d", k), uo1, e);
      end

      // frame counter: 9 pulses on 3-bit counter wrap 7->0
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         vs_pulse(2, 2, t0, t1);
         chk($sformatf("fc0_p%0d", i), fc0, i % 8);
         chk($sformatf("tick0_p%0d", i), t0, 1);
         chk($sformatf("tick1_p%0d", i), t1, 1);
      end
      chk("fc1_after9", fc1, 9);
      vs_pulse(12, 1, t0, t1);
      chk("held_vs_tick", t0, 1);
      chk("held_vs_fc0", fc0, 2);

      // temporal rotation at (0,0), r=0x20: T = 0,8,2,10 over frames 0..3
      do_reset();
      hpos_lsb = 2'd0; vpos_lsb = 2'd0;
      r_in = 8'h20; g_in = 8'h00; b_in = 8'h00; dither_en = 1'b1; display_on = 1'b1;
      repeat (8) @(negedge clk);
      for (int f = 0; f < 4; f++) begin
         if (f > 0) vs_pulse(2, 8, t0, t1);
         chk($sformatf("temporal_fc%0d", f), fc1, f);
         e = (f[0] == 1'b0) ? 8'h98 : 8'h88;
         chk($sformatf("temporal_uo1_f%0d", f), uo1, e);
         chk($sformatf("static_uo0_f%0d", f), uo0, 8'h98);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks %0d", n_chk);
      $fatal(1);
   end

endmodule
